grid_sched: RTL and testbench
=============================

GRID_SCHED -- requirements
Module: grid_sched

Interface
REQ-001 Parameter GRID_W, default 7, log2 of grid side (128x128 grid).
REQ-002 Parameter SUPPORT, default 4, kernel taps per dimension (2..8, even).
REQ-003 Parameter PIPE_LAT, default 6, accumulator read-modify-write latency in cycles (2..32).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 start  in  1  pulse to begin a run; ignored unless idle.
REQ-007 n_target  in  32  samples in the run, sampled on start.
REQ-008 s_valid / s_ready  in / out  1 / 1  sample handshake.
REQ-009 s_u, s_v  in  GRID_W each  sample base column and row.
REQ-010 tap_valid / acc_ready  out / in  1 / 1  tap issue handshake to the MAC datapath.
REQ-011 tap_x, tap_y  out  3 each  kernel tap indices.
REQ-012 grid_index  out  2*GRID_W  {row,col} of the current tap.
REQ-013 smp_done  out  1  one-cycle pulse when a sample's last tap is retired.
REQ-014 busy  out  1  high in FETCH, ISSUE and DRAIN.
REQ-015 done  out  1  one-cycle pulse at end of run.
REQ-016 n_cycles, n_samples  out  32 each  busy-cycle count and completed-sample count.

Function
REQ-017 States: IDLE, FETCH, ISSUE, DRAIN, DONE.
REQ-018 IDLE: start with n_target!=0 clears both counters and goes to FETCH; start with n_target==0 goes to DONE.
REQ-019 FETCH: s_ready=1; on s_valid&&s_ready latch s_u/s_v, set tap=(0,0), go to ISSUE; s_ready=0 in every other state.
REQ-020 ISSUE: col = u+tap_x-SUPPORT/2, row = v+tap_y-SUPPORT/2, computed signed with no wrap.
REQ-021 A tap with col or row outside [0, 2^GRID_W-1] is skipped: tap_valid stays 0 and the tap advances after exactly one cycle.
REQ-022 An in-range tap is blocked while its grid_index equals an index accepted in cycle t, until cycle t+PIPE_LAT; while blocked, tap_valid=0 and the tap holds.
REQ-023 An unblocked in-range tap asserts tap_valid; tap_valid, grid_index, tap_x and tap_y stay stable until acc_ready; acceptance happens on tap_valid&&acc_ready.
REQ-024 Tap order: tap_x fastest, 0..SUPPORT-1, then tap_y.
REQ-025 Retiring tap (SUPPORT-1, SUPPORT-1), by accept or skip: pulse smp_done and increment n_samples; go to DRAIN if the new count equals n_target, else to FETCH.
REQ-026 DRAIN: wait until no accepted index is in flight (< PIPE_LAT cycles old), then go to DONE.
REQ-027 DONE: done=1 for one cycle, then IDLE; both counters hold until the next accepted start.
REQ-028 n_cycles increments on every cycle with busy=1; both counters wrap modulo 2^32.
REQ-029 In-flight tracking ages every cycle, independent of stalls and acc_ready.

Reset
REQ-030 rst=0 at a clock edge forces IDLE, even mid-run, and after that edge drives tap_valid, s_ready, smp_done, busy, done = 0, n_cycles = n_samples = 0, grid_index = tap_x = tap_y = 0, and clears all in-flight entries.

Verification
REQ-031 Defaults, acc_ready=1, n_target=1, sample u=10,v=20 -> first accepted grid_index 2312 (row 18, col 8), last 2699; 16 accepts; smp_done once; done 6 cycles after last accept; n_samples=1.
REQ-032 Sample u=0,v=0 -> only taps (2,2),(3,2),(2,3),(3,3) issue with indices 0,1,128,129; 12 skips; ISSUE lasts 16 cycles.
REQ-033 PIPE_LAT=20, two samples u=0,v=0 back-to-back -> index 0 of sample 2 accepted exactly 20 cycles after sample 1's index 0, after 3 stall cycles.
REQ-034 acc_ready held low 5 cycles on the first tap -> tap_valid and grid_index stable throughout; no tap lost; totals unchanged.
REQ-035 rst=0 during ISSUE of a 3-sample run -> all outputs zero next cycle; a new start runs cleanly with n_cycles counted from 0.
REQ-036 start with n_target=0 -> done pulse 1 cycle later; busy never asserts; counters 0.

Source files
------------

// File: rtl/grid_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : grid_sched_if
//  Description : Sample-fetch and tap-issue channels of the grid scheduler.
//                master = scheduler side, slave = sample source / MAC side.
//  Revision    : 1.0  initial release
// ============================================================================
interface grid_sched_if #(
    parameter int GRID_W = 7
);
    logic                  s_valid;
    logic                  s_ready;
    logic [GRID_W-1:0]     s_u;
    logic [GRID_W-1:0]     s_v;
    logic                  tap_valid;
    logic                  acc_ready;
    logic [2:0]            tap_x;
    logic [2:0]            tap_y;
    logic [2*GRID_W-1:0]   grid_index;

    modport master (
        input  s_valid, s_u, s_v, acc_ready,
        output s_ready, tap_valid, tap_x, tap_y, grid_index
    );

    modport slave (
        output s_valid, s_u, s_v, acc_ready,
        input  s_ready, tap_valid, tap_x, tap_y, grid_index
    );
endinterface
`default_nettype wire

// File: rtl/grid_sched.sv
`default_nettype none
// ============================================================================
//  Module      : grid_sched
//  Description : Walks a SUPPORT x SUPPORT kernel footprint around each sample,
//                skipping off-grid taps and stalling read-after-write hazards.
//  Revision    : 1.0  initial release
// ============================================================================
module grid_sched #(
    parameter int GRID_W   = 7,
    parameter int SUPPORT  = 4,
    parameter int PIPE_LAT = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic [31:0] n_target,
    grid_sched_if.master     bus,
    output logic             smp_done,
    output logic             busy,
    output logic             done,
    output logic [31:0]      n_cycles,
    output logic [31:0]      n_samples
);
    localparam int                c_cw       = GRID_W + 2;
    localparam int                c_depth    = PIPE_LAT - 1;
    localparam logic [2:0]        c_tap_last = 3'(SUPPORT - 1);
    localparam logic [c_cw-1:0]   c_half     = c_cw'(SUPPORT / 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [GRID_W-1:0]     r_u;
    logic [GRID_W-1:0]     r_v;
    logic [2:0]            r_tap_x;
    logic [2:0]            r_tap_y;
    logic [31:0]           r_target;
    logic [31:0]           r_n_cycles;
    logic [31:0]           r_n_samples;
    logic                  r_fl_vld [c_depth];
    logic [2*GRID_W-1:0]   r_fl_idx [c_depth];

    logic [c_cw-1:0]       w_col;
    logic [c_cw-1:0]       w_row;
    logic                  w_in_range;
    logic [2*GRID_W-1:0]   w_idx;
    logic                  w_blocked;
    logic                  w_draining;
    logic                  w_issue;
    logic                  w_tap_valid;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_last_tap;
    logic                  w_retire;
    logic                  w_fetch_hs;
    logic                  w_target_hit;
    logic                  w_start_run;
    logic                  w_busy;
    logic                  w_s_ready;

    // Modular arithmetic: any negative or >= 2^GRID_W coordinate leaves a
    // non-zero value in the two guard bits.
    assign w_col      = {2'b00, r_u} + c_cw'(r_tap_x) - c_half;
    assign w_row      = {2'b00, r_v} + c_cw'(r_tap_y) - c_half;
    assign w_in_range = (w_col[c_cw-1:GRID_W] == 2'b00) && (w_row[c_cw-1:GRID_W] == 2'b00);
    assign w_idx      = {w_row[GRID_W-1:0], w_col[GRID_W-1:0]};

    assign w_issue      = (r_state == ST_ISSUE);
    assign w_tap_valid  = w_issue && w_in_range && !w_blocked;
    assign w_accept     = w_tap_valid && bus.acc_ready;
    assign w_advance    = w_issue && (!w_in_range || w_accept);
    assign w_last_tap   = (r_tap_x == c_tap_last) && (r_tap_y == c_tap_last);
    assign w_retire     = w_advance && w_last_tap;
    assign w_fetch_hs   = (r_state == ST_FETCH) && bus.s_valid;
    assign w_target_hit = ((r_n_samples + 32'd1) == r_target);
    assign w_start_run  = (r_state == ST_IDLE) && start && (n_target != 32'd0);

    // Entry i holds an index accepted i+1 cycles ago; the oldest entry expires
    // at the next edge, so it no longer holds up the drain.
    always_comb begin
        w_blocked  = 1'b0;
        w_draining = 1'b0;
        for (int i = 0; i < c_depth; i++) begin
            if (r_fl_vld[i] && (r_fl_idx[i] == w_idx)) begin
                w_blocked = 1'b1;
            end
        end
        for (int i = 0; i < c_depth - 1; i++) begin
            if (r_fl_vld[i]) begin
                w_draining = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_s_ready   = 1'b0;
        done        = 1'b0;
        smp_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (n_target != 32'd0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                w_busy    = 1'b1;
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_busy   = 1'b1;
                smp_done = w_retire;
                if (w_retire) begin
                    w_state_nxt = w_target_hit ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!w_draining) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_u         <= '0;
            r_v         <= '0;
            r_tap_x     <= '0;
            r_tap_y     <= '0;
            r_target    <= '0;
            r_n_cycles  <= '0;
            r_n_samples <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_fl_vld[i] <= 1'b0;
                r_fl_idx[i] <= '0;
            end
        end else begin
            if (w_start_run) begin
                r_target    <= n_target;
                r_n_cycles  <= '0;
                r_n_samples <= '0;
            end else begin
                if (w_busy) begin
                    r_n_cycles <= r_n_cycles + 32'd1;
                end
                if (w_retire) begin
                    r_n_samples <= r_n_samples + 32'd1;
                end
            end

            if (w_fetch_hs) begin
                r_u     <= bus.s_u;
                r_v     <= bus.s_v;
                r_tap_x <= '0;
                r_tap_y <= '0;
            end else if (w_advance) begin
                if (r_tap_x == c_tap_last) begin
                    r_tap_x <= '0;
                    r_tap_y <= (r_tap_y == c_tap_last) ? 3'd0 : r_tap_y + 3'd1;
                end else begin
                    r_tap_x <= r_tap_x + 3'd1;
                end
            end

            // Ages every cycle regardless of stalls.
            r_fl_vld[0] <= w_accept;
            r_fl_idx[0] <= w_idx;
            for (int i = 1; i < c_depth; i++) begin
                r_fl_vld[i] <= r_fl_vld[i-1];
                r_fl_idx[i] <= r_fl_idx[i-1];
            end
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.tap_valid  = w_tap_valid;
    assign bus.tap_x      = r_tap_x;
    assign bus.tap_y      = r_tap_y;
    assign bus.grid_index = w_issue ? w_idx : '0;
    assign busy           = w_busy;
    assign n_cycles       = r_n_cycles;
    assign n_samples      = r_n_samples;
endmodule
`default_nettype wire

// File: tb/tb_grid_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_sched
//  Description : Scoreboard bench for grid_sched: footprint model feeds an
//                expected-tap queue, a negedge monitor checks every accept.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_grid_sched;
    localparam int GRID_W   = 7;
    localparam int SUPPORT  = 4;
    localparam int PIPE_LAT = 6;
    localparam int SIDE     = 1 << GRID_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n_target = '0;
    logic        smp_done, busy, done;
    logic [31:0] n_cycles, n_samples;

    grid_sched_if #(.GRID_W(GRID_W)) bus ();

    grid_sched #(.GRID_W(GRID_W), .SUPPORT(SUPPORT), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_target  (n_target),
        .bus       (bus.master),
        .smp_done  (smp_done),
        .busy      (busy),
        .done      (done),
        .n_cycles  (n_cycles),
        .n_samples (n_samples)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int tx; int ty;} tap_t;
    typedef struct {int c; int idx;} acc_t;

    tap_t exp_q[$];
    acc_t acc_log[$];
    int   hs_log[$];
    int   last_acc[int];
    int   su_q[$];
    int   sv_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt, smp_cnt, done_cnt, stall_cnt;
    int first_idx, last_idx, last_acc_cyc, smp_cyc, done_cyc, hs_cyc;
    bit acc_mode  = 1'b0;
    bit acc_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference footprint: every on-grid tap in x-fastest order.
    function automatic void push_sample(input int u, input int v);
        for (int ty = 0; ty < SUPPORT; ty++) begin
            for (int tx = 0; tx < SUPPORT; tx++) begin
                int col = u + tx - SUPPORT / 2;
                int row = v + ty - SUPPORT / 2;
                if (col >= 0 && col < SIDE && row >= 0 && row < SIDE)
                    exp_q.push_back('{row * SIDE + col, tx, ty});
            end
        end
    endfunction

    function automatic int pick_coord();
        case ($urandom_range(0, 2))
            0:       return $urandom_range(0, 3);
            1:       return $urandom_range(SIDE - 4, SIDE - 1);
            default: return $urandom_range(0, SIDE - 1);
        endcase
    endfunction

    task automatic clear_stats();
        acc_cnt = 0; smp_cnt = 0; done_cnt = 0; stall_cnt = 0;
        first_idx = -1; last_idx = -1; last_acc_cyc = 0; smp_cyc = 0; done_cyc = 0; hs_cyc = 0;
        acc_log.delete();
        hs_log.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.acc_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.acc_ready = acc_mode ? ($urandom_range(0, 3) != 0) : acc_force;
        end
    end

    // Monitor: pops the scoreboard on every accepted tap.
    initial begin
        tap_t                e;
        bit                  prev_hold;
        logic [2*GRID_W-1:0] prev_idx;
        logic [5:0]          prev_tap;
        int                  idx;
        prev_hold = 1'b0;
        prev_idx  = '0;
        prev_tap  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_acc.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold)
                    check("hold_stable", {bus.tap_valid, bus.grid_index, bus.tap_x, bus.tap_y},
                          {1'b1, prev_idx, prev_tap});
                if (bus.s_valid && bus.s_ready) begin
                    hs_cyc = cyc;
                    hs_log.push_back(cyc);
                end
                if (bus.tap_valid && !bus.acc_ready) stall_cnt++;
                if (bus.tap_valid && bus.acc_ready) begin
                    idx = int'(bus.grid_index);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_accept: got index %0d, expected no accept", idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("accept_index", bus.grid_index, e.idx);
                        check("accept_tap", {bus.tap_x, bus.tap_y}, {e.tx[2:0], e.ty[2:0]});
                    end
                    if (last_acc.exists(idx))
                        check("hazard_gap_ok", (cyc - last_acc[idx]) >= PIPE_LAT, 1);
                    last_acc[idx] = cyc;
                    acc_cnt++;
                    if (acc_cnt == 1) first_idx = idx;
                    last_idx     = idx;
                    last_acc_cyc = cyc;
                    acc_log.push_back('{cyc, idx});
                end
                if (smp_done) begin smp_cnt++; smp_cyc = cyc; end
                if (done) begin done_cnt++; done_cyc = cyc; end
                prev_hold = bus.tap_valid && !bus.acc_ready;
                prev_idx  = bus.grid_index;
                prev_tap  = {bus.tap_x, bus.tap_y};
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic run_samples(input bit gaps);
        int n;
        int t;
        n = su_q.size();
        clear_stats();
        n_target = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            bus.s_u = su_q[i][GRID_W-1:0];
            bus.s_v = sv_q[i][GRID_W-1:0];
            bus.s_valid = 1'b1;
            push_sample(su_q[i], sv_q[i]);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(bus.s_ready) && t < 2000);
            check("fetch_handshake_in_time", t < 2000, 1);
            tick();
        end
        bus.s_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 2000);
        check("done_in_time", t < 2000, 1);
        tick();
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("smp_done_pulses", smp_cnt, n);
        check("n_samples", n_samples, n);
    endtask

    initial begin
        int c128[$];
        int t;
        bus.s_valid = 1'b0;
        bus.s_u = '0;
        bus.s_v = '0;
        clear_stats();
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset_outputs", {bus.tap_valid, bus.s_ready, smp_done, busy, done},  5'b0);
        check("reset_counters", {n_cycles, n_samples}, 64'd0);
        check("reset_tap", {bus.grid_index, bus.tap_x, bus.tap_y}, 0);

        // Zero-length run
        tick();
        clear_stats();
        n_target = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero_run_done", done, 1);
        check("zero_run_busy", busy, 0);
        @(negedge clk);
        check("zero_run_done_clear", done, 0);
        check("zero_run_busy2", busy, 0);
        check("zero_run_counters", {n_cycles, n_samples}, 64'd0);
        tick();

        // Fully interior sample
        acc_mode = 1'b0; acc_force = 1'b1;
        su_q = '{10}; sv_q = '{20};
        run_samples(1'b0);
        check("interior_first_idx", first_idx, 2312);
        check("interior_last_idx", last_idx, 2699);
        check("interior_accepts", acc_cnt, 16);
        check("interior_done_latency", done_cyc - last_acc_cyc, PIPE_LAT);
        check("interior_n_cycles", n_cycles, 22);

        // Corner sample: 12 skipped taps
        su_q = '{0}; sv_q = '{0};
        run_samples(1'b0);
        check("corner_accepts", acc_cnt, 4);
        check("corner_first_idx", first_idx, 0);
        check("corner_last_idx", last_idx, 129);
        check("corner_issue_len", smp_cyc - hs_cyc, 16);
        check("corner_n_cycles", n_cycles, 22);

        // Hazard: index 128 reused right after the first sample
        su_q = '{0, 2}; sv_q = '{0, 3};
        run_samples(1'b0);
        c128.delete();
        foreach (acc_log[i]) if (acc_log[i].idx == 128) c128.push_back(acc_log[i].c);
        check("hazard_idx128_count", c128.size(), 2);
        check("hazard_hs_count", hs_log.size(), 2);
        if (c128.size() == 2 && hs_log.size() == 2) begin
            check("hazard_gap", c128[1] - c128[0], PIPE_LAT);
            check("hazard_stall", c128[1] - hs_log[1], 4);
        end

        // Back-pressure on the first tap for 5 cycles
        acc_force = 1'b0;
        su_q = '{10}; sv_q = '{20};
        fork
            run_samples(1'b0);
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!bus.tap_valid && t < 200);
                check("bp_tap_seen", t < 200, 1);
                repeat (4) @(negedge clk);
                acc_force = 1'b1;
            end
        join
        check("bp_stall_cycles", stall_cnt, 5);
        check("bp_accepts", acc_cnt, 16);
        check("bp_first_idx", first_idx, 2312);
        check("bp_n_cycles", n_cycles, 27);

        // Reset in the middle of a 3-sample run
        clear_stats();
        n_target = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.s_u = 7'd50; bus.s_v = 7'd50; bus.s_valid = 1'b1;
        for (int i = 0; i < 3; i++) push_sample(50, 50);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(acc_cnt >= 5 && bus.tap_valid) && t < 500);
        check("midrst_in_issue", bus.tap_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {bus.tap_valid, bus.s_ready, smp_done, busy, done}, 5'b0);
        check("midrst_counters", {n_cycles, n_samples}, 64'd0);
        check("midrst_tap", {bus.grid_index, bus.tap_x, bus.tap_y}, 0);
        bus.s_valid = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        su_q = '{10}; sv_q = '{20};
        run_samples(1'b0);
        check("post_rst_n_cycles", n_cycles, 22);
        check("post_rst_accepts", acc_cnt, 16);

        // Randomized runs with random back-pressure and fetch gaps
        acc_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 4);
            su_q.delete(); sv_q.delete();
            for (int k = 0; k < n; k++) begin
                su_q.push_back(pick_coord());
                sv_q.push_back(pick_coord());
            end
            run_samples(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
